// File: rtl/hdmi_timing_scheduler.sv
// Video timing generator for a 3-channel TMDS transmitter: raster counters, pixel fetch
// strobe, and registered VDE / pixel / control-data outputs with sync polarity control.
module hdmi_timing_scheduler #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        TMDS_local_clk,
  input  logic        TMDS_local_rst,
  input  logic        enable,
  output logic        pix_req,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic [7:0]  VD_r,
  output logic [7:0]  VD_g,
  output logic [7:0]  VD_b,
  output logic [1:0]  CD_r,
  output logic [1:0]  CD_g,
  output logic [1:0]  CD_b,
  output logic        VDE,
  output logic        frame_start,
  output logic        underflow,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra count of headroom so every window bound (up to the total) is representable.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d, h_inc;
  logic [VW-1:0] v_cnt_q, v_cnt_d, v_inc;
  logic          h_wrap, v_last, run_st, active, hs_on, vs_on;

  always_comb begin
    h_wrap = (h_cnt_q == H_LAST);
    v_last = (v_cnt_q == V_LAST);
    h_inc  = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_inc  = v_cnt_q;
    if (h_wrap) v_inc = v_last ? '0 : v_cnt_q + VW'(1);
  end

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_inc;
    v_cnt_d = v_inc;
    case (state_q)
      S_IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Re-enable wins over the end-of-frame exit so the raster never pauses.
        if (enable)                 state_d = S_RUN;
        else if (h_wrap && v_last)  state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        h_cnt_d = '0;
        v_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    run_st = (state_q != S_IDLE);
    active = run_st && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_on  = run_st && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_on  = run_st && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  end

  // Combinational so the source sees the request one cycle ahead of VDE.
  assign pix_req = active;
  assign CD_r    = 2'b00;
  assign CD_g    = 2'b00;

  always_ff @(posedge TMDS_local_clk) begin
    if (TMDS_local_rst) begin
      state_q     <= S_IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      VDE         <= 1'b0;
      VD_r        <= 8'h00;
      VD_g        <= 8'h00;
      VD_b        <= 8'h00;
      CD_b        <= {~VS_POL, ~HS_POL};
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      running     <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      VDE         <= active;
      CD_b        <= {(vs_on ? VS_POL : ~VS_POL), (hs_on ? HS_POL : ~HS_POL)};
      frame_start <= run_st && (h_cnt_q == '0) && (v_cnt_q == '0);
      running     <= run_st;
      if (active && pix_valid) begin
        VD_r <= pix_data[23:16];
        VD_g <= pix_data[15:8];
        VD_b <= pix_data[7:0];
      end else begin
        VD_r <= 8'h00;
        VD_g <= 8'h00;
        VD_b <= 8'h00;
      end
      if (active && !pix_valid) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_scheduler.sv
// Scoreboard bench for hdmi_timing_scheduler on a tiny 8x5 raster: the driver pushes the
// expected registered response per clock, a negedge monitor pops and compares.
module tb_hdmi_timing_scheduler;

  logic        clk, rst, enable, pix_valid;
  logic [23:0] pix_data;
  logic        pix_req, VDE, frame_start, underflow, running;
  logic [7:0]  VD_r, VD_g, VD_b;
  logic [1:0]  CD_r, CD_g, CD_b;

  hdmi_timing_scheduler #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .TMDS_local_clk(clk), .TMDS_local_rst(rst), .enable(enable),
    .pix_req(pix_req), .pix_valid(pix_valid), .pix_data(pix_data),
    .VD_r(VD_r), .VD_g(VD_g), .VD_b(VD_b),
    .CD_r(CD_r), .CD_g(CD_g), .CD_b(CD_b),
    .VDE(VDE), .frame_start(frame_start), .underflow(underflow), .running(running)
  );

  typedef struct {
    logic        vde;
    logic [23:0] vd;
    logic [1:0]  cdb;
    logic        fs;
    logic        uf;
    logic        run;
    logic        preq;
  } exp_t;

  exp_t sb[$];
  exp_t mx;
  int   n_pass = 0;
  int   n_total = 0;
  int   m_st = 0;       // 0 idle, 1 run, 2 drain
  int   m_pos = 0;      // position within the 40-cycle frame
  logic m_uf = 1'b0;
  int   cyc = 0;
  int   fs_prev = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
  endtask

  task automatic step(input logic r, input logic e, input logic pv, input logic [23:0] pd);
    exp_t x;
    int   h, v;
    logic on, act;
    rst = r; enable = e; pix_valid = pv; pix_data = pd;
    h = m_pos % 8; v = m_pos / 8;
    on  = (m_st != 0);
    act = on && (h < 4) && (v < 2);
    if (r) begin
      x.vde = 1'b0; x.vd = 24'h0; x.cdb = 2'b11; x.fs = 1'b0; x.run = 1'b0;
      m_uf = 1'b0; x.uf = 1'b0;
      m_st = 0; m_pos = 0;
    end else begin
      x.vde = act;
      x.vd  = (act && pv) ? pd : 24'h0;
      if (act && !pv) m_uf = 1'b1;
      x.uf  = m_uf;
      x.cdb = {~(on && v == 3), ~(on && (h == 5 || h == 6))};
      x.fs  = on && (m_pos == 0);
      x.run = on;
      case (m_st)
        0: if (e) begin m_st = 1; m_pos = 0; end
        1: begin m_pos = (m_pos + 1) % 40; if (!e) m_st = 2; end
        default: begin
          if (!e && m_pos == 39) begin m_st = 0; m_pos = 0; end
          else begin m_pos = (m_pos + 1) % 40; if (e) m_st = 1; end
        end
      endcase
    end
    h = m_pos % 8; v = m_pos / 8;
    x.preq = (m_st != 0) && (h < 4) && (v < 2);
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic run_to(input int p, input logic [23:0] pd);
    for (int g = 0; g < 60 && m_pos != p; g++) step(1'b0, 1'b1, 1'b1, pd);
    chk("run_to_pos", m_pos, p);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      chk("vde",         32'(VDE),              32'(mx.vde));
      chk("vd_rgb",      32'({VD_r, VD_g, VD_b}), 32'(mx.vd));
      chk("cd_b",        32'(CD_b),             32'(mx.cdb));
      chk("cd_rg",       32'({CD_r, CD_g}),     32'h0);
      chk("frame_start", 32'(frame_start),      32'(mx.fs));
      chk("underflow",   32'(underflow),        32'(mx.uf));
      chk("running",     32'(running),          32'(mx.run));
      chk("pix_req",     32'(pix_req),          32'(mx.preq));
    end
    if (running !== 1'b1) fs_prev = -1;
    else if (frame_start === 1'b1) begin
      if (fs_prev >= 0) chk("fs_gap", cyc - fs_prev, 40);
      fs_prev = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n;
    rst = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_data = 24'h0;
    repeat (3) step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("rst_cdb", CD_b, 2'b11);
    chk("rst_vde", VDE, 0);

    // Two full frames of solid colour.
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'b1, 1'b1, 24'hAABBCC);
      if (pix_req) cnt++;
    end
    chk("preq_per_2frames", cnt, 16);

    // One starved pixel at (0,0); flag must persist through the next frame.
    run_to(0, 24'hAABBCC);
    step(1'b0, 1'b1, 1'b0, 24'h123456);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, {8'(i), 8'hC3, 8'h5A});
    chk("uf_sticky", underflow, 1);

    // Drop enable at line 1, pixel 2: the frame must finish before IDLE.
    run_to(10, 24'h0F0F0F);
    step(1'b0, 1'b0, 1'b1, 24'h0F0F0F);
    n = 1;
    while (running && n < 100) begin
      step(1'b0, 1'b0, 1'b1, 24'h0F0F0F);
      n++;
    end
    chk("drain_len", n, 31);
    cnt = 0;
    repeat (10) begin
      step(1'b0, 1'b0, 1'b1, 24'h0F0F0F);
      if (pix_req) cnt++;
    end
    chk("idle_preq", cnt, 0);
    chk("uf_still_set", underflow, 1);

    // Reset during an active pixel aborts immediately.
    step(1'b0, 1'b1, 1'b1, 24'h445566);
    run_to(2, 24'h445566);
    step(1'b1, 1'b1, 1'b1, 24'h445566);
    chk("midrst_vde", VDE, 0);
    chk("midrst_cdb", CD_b, 2'b11);
    chk("midrst_preq", pix_req, 0);
    chk("midrst_uf", underflow, 0);

    // Restart, then a short enable drop inside DRAIN must not break the cadence.
    step(1'b0, 1'b1, 1'b1, 24'h778899);
    chk("restart_preq", pix_req, 1);
    run_to(20, 24'h778899);
    repeat (5) step(1'b0, 1'b0, 1'b1, 24'h778899);
    cnt = 0;
    repeat (70) begin
      step(1'b0, 1'b1, 1'b1, 24'h778899);
      if (!running) cnt++;
    end
    chk("no_idle_in_drain", cnt, 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
